// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM states and derived sizes.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Digit counter width; never narrower than one bit so NDIG=1 still has a counter.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_n_serial_digit.sv
// DIGIT-bit ripple chain of full_adder_1 cells; also exposes the carry into its MSB.
module digit_adder_n #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder_1 u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/full_adder_1.sv
// Single-bit full adder cell shared across the team's ripple adders.
module full_adder_1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_n_serial.sv
// Digit-serial add/subtract: WIDTH-bit operands, DIGIT bits per clock, LSB digit first,
// valid/ready on both sides, reports carry-out and signed overflow.
module adder_n_serial
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("adder_n_serial: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
  localparam int unsigned CW   = cnt_w(NDIG);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry, cout_r, ovf_r;

  logic             accept, last;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout, d_cmsb;

  assign in_ready  = (state == IDLE) & rst_n;
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CW'(NDIG - 1));

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

  // Operands shift right one digit per RUN cycle, so the active digit is always the low slice.
  digit_adder_n #(.DIGIT(DIGIT)) u_digit (
    .a    (a_r[DIGIT-1:0]),
    .b    (b_r[DIGIT-1:0]),
    .cin  (carry),
    .s    (d_sum),
    .cout (d_cout),
    .cmsb (d_cmsb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + ~borrow; result digits enter at the top and shift down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r   <= in1;
            b_r   <= sub ? ~in2 : in2;
            carry <= cin ^ sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_r   <= a_r >> DIGIT;
          b_r   <= b_r >> DIGIT;
          sum_r <= (sum_r >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));
          carry <= d_cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            cout_r <= d_cout;
            ovf_r  <= d_cmsb ^ d_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_n_serial.sv
// Scoreboard bench for adder_n_serial across several WIDTH/DIGIT configurations run side by side.
module tb_adder_n_serial;

  localparam int NCFG = 5;
  localparam int NVEC = 1000;
  localparam int CFG_W [NCFG] = '{8, 8, 8, 16, 12};
  localparam int CFG_D [NCFG] = '{2, 1, 8, 4, 3};

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int unsigned t_acc;
  } exp_t;

  logic        clk = 1'b0;
  int unsigned cyc = 0;
  int          errs = 0;
  int          checks = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic s);
    exp_t   m;
    longint md, ua, ub, sa, sb, c, ru, rs;
    md = longint'(1) << w;
    ua = longint'(a) & (md - 1);
    ub = longint'(b) & (md - 1);
    sa = (ua >= md / 2) ? ua - md : ua;
    sb = (ub >= md / 2) ? ub - md : ub;
    c  = ci ? 1 : 0;
    ru = s ? (ua - ub - c) : (ua + ub + c);
    rs = s ? (sa - sb - c) : (sa + sb + c);
    m.sum   = 16'(ru & (md - 1));
    m.cout  = s ? (ru >= 0) : (ru >= md);
    m.ovf   = (rs < -(md / 2)) || (rs >= md / 2);
    m.t_acc = 0;
    return m;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = CFG_W[g];
    localparam int D = CFG_D[g];
    localparam int N = W / D;

    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    exp_t q[$];

    adder_n_serial #(.WIDTH(W), .DIGIT(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
    );

    task automatic check(input string name, input longint act, input longint want);
      checks++;
      if (act != want) begin
        errs++;
        $display("FAIL cfg%0d W=%0d D=%0d %s: got 'h%0h, expected 'h%0h", g, W, D, name, act, want);
      end
    endtask

    // keep=0: abandon the operation with a one-cycle reset pulse while it is in RUN.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic s, input bit keep);
      exp_t e;
      int   k;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in1 = W'(a);
      in2 = W'(b);
      cin = ci;
      sub = s;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) begin
        check("accept timeout", k, 0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in1 = W'($urandom);
      in2 = W'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      if (keep) begin
        e = model(W, a, b, ci, s);
        e.t_acc = cyc;
        q.push_back(e);
      end else begin
        rst_n = 1'b0;
        @(negedge clk);
        check("in_ready/out_valid while reset low", {in_ready, out_valid}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset release", in_ready, 1);
        repeat (N + 3) begin
          @(negedge clk);
          check("no out_valid for abandoned op", out_valid, 0);
        end
      end
    endtask

    task automatic wait_empty();
      int k = 0;
      while (q.size() != 0 && k < 2000) begin
        @(negedge clk);
        k++;
      end
      if (q.size() != 0) check("drain timeout", q.size(), 0);
    endtask

    initial begin
      forever begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 2) != 0);
      end
    end

    // Monitor: pops and compares on each accepted result, and checks hold/handover behaviour.
    bit          seen = 0, p_hold = 0, p_fire = 0, p_cout = 0, p_ovf = 0;
    logic [W-1:0] p_sum = '0;
    always @(negedge clk) begin
      if (!rst_n) begin
        seen   = 0;
        p_hold = 0;
        p_fire = 0;
      end else begin
        if (p_hold)
          check("held outputs under backpressure", {out_valid, in_ready, cout, ovf, sum},
                {1'b1, 1'b0, p_cout, p_ovf, p_sum});
        if (p_fire)
          check("out_valid/in_ready after pop", {out_valid, in_ready}, 2'b01);
        if (out_valid) begin
          check("pending op behind out_valid", q.size() > 0, 1);
          if (q.size() > 0) begin
            if (!seen) begin
              check("latency", cyc - q[0].t_acc, N);
              seen = 1;
            end
            if (out_ready) begin
              check("sum", sum, W'(q[0].sum));
              check("cout", cout, q[0].cout);
              check("ovf", ovf, q[0].ovf);
              void'(q.pop_front());
              seen = 0;
            end
          end
        end
        p_hold = out_valid && !out_ready;
        p_fire = out_valid && out_ready;
        p_sum  = sum;
        p_cout = cout;
        p_ovf  = ovf;
      end
    end

    initial begin
      logic [15:0] ones, maxpos, minneg;
      logic [15:0] ta [6], tb [6];
      bit          tc [6], ts [6];
      ones   = 16'((32'd1 << W) - 1);
      maxpos = ones >> 1;
      minneg = maxpos + 16'd1;
      ta = '{ones,  maxpos, 16'h12, 16'h05, minneg, 16'h10};
      tb = '{16'h1, 16'h1,  16'h34, 16'h07, 16'h1,  16'h0F};
      tc = '{0, 0, 1, 0, 0, 1};
      ts = '{0, 0, 0, 1, 1, 1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs", {in_ready, out_valid, cout, ovf, sum}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready after reset", in_ready, 1);

      for (int i = 0; i < 6; i++) send(ta[i], tb[i], tc[i], ts[i], 1'b1);
      wait_empty();

      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

      for (int i = 0; i < NVEC; i++)
        send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      wait_empty();
      done_cnt++;
    end
  end

  initial begin
    while (done_cnt < NCFG && cyc < 60000) @(posedge clk);
    if (done_cnt < NCFG) begin
      checks++;
      errs++;
      $display("FAIL global timeout: configs finished %0d, expected %0d", done_cnt, NCFG);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/adder_n_serial.md
Name: adder_n_serial

Overview:
- Parametrised, digit-serial successor to the team's fixed 8-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands, processing DIGIT bits per clock, LSB digit first, through a DIGIT-bit ripple chain.
- Trades latency for area. Uses valid/ready handshakes on both sides so it drops into streaming datapaths.
- Reports carry-out and signed overflow.

Parameters:
- WIDTH, 8, operand and result width in bits.
- DIGIT, 2, bits processed per cycle. WIDTH % DIGIT == 0 and 1 <= DIGIT <= WIDTH, else elaboration error.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+cin, 1 = A-B-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out. In sub mode, 1 = no borrow.
- ovf  out  1  signed (two's-complement) overflow.

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low.
- NDIG = WIDTH/DIGIT.
- FSM states: IDLE, RUN, DONE.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; digit counter=0.
  - Operand, result, carry registers cleared.
  - sum=0, cout=0, ovf=0, out_valid=0.
  - in_ready = (state==IDLE) & rst_n, so in_ready is 0 while rst_n is low.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch in1 into A; latch B = sub ? ~in2 : in2; carry = sub ? ~cin : cin; counter=0; go to RUN.
  - in1/in2/cin/sub are sampled only at the accept edge; later changes are ignored.
- RUN:
  - in_ready=0.
  - Each cycle, digit k=counter: sum bits [k*DIGIT +: DIGIT] = A_k + B_k + carry; carry updates to the digit carry-out.
  - On the final digit (k=NDIG-1): cout = MSB carry-out; ovf = carry into MSB XOR carry out of MSB. Go to DONE.
- DONE:
  - out_valid=1; sum/cout/ovf held stable.
  - On out_ready: out_valid drops next cycle, go to IDLE.
  - in_valid is ignored in DONE; no overlap between operations.
- Latency: out_valid rises exactly NDIG cycles after the accept edge.
- Throughput: one result per NDIG+2 cycles with out_ready held high.
- DIGIT=WIDTH: RUN lasts one cycle.
- sum/cout/ovf are defined only while out_valid=1; their contents during RUN are unspecified but deterministic.
- Wrap-around: sum is modulo 2^WIDTH; carry is reported only via cout.
- Reset mid-RUN or mid-DONE: operation abandoned, no out_valid, return to IDLE.
- Backpressure: out_ready low holds DONE indefinitely with all outputs constant.

Decomposition:
- Shared package adder_pkg:
  - state enum (IDLE, RUN, DONE).
  - function/constant for NDIG.
  - counter width $clog2(NDIG) with a minimum of 1.
- One natural sub-module: digit_adder_n, a DIGIT-bit ripple chain of the existing full_adder_1 cells.
  - Exposes sum, carry-out and carry into its MSB, needed for ovf.

Test Plan:
1. WIDTH=8, DIGIT=2, add, 8'hFF+8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0; out_valid exactly 4 cycles after accept.
2. Add 8'h7F+8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. Add 8'h12+8'h34, cin=1 -> 8'h47, cout=0, ovf=0.
3. sub=1, 8'h05-8'h07, cin=0 -> sum=8'hFE, cout=0, ovf=0. 8'h80-8'h01 -> 8'h7F, cout=1, ovf=1. 8'h10-8'h0F, cin=1 -> 8'h00, cout=1.
4. Backpressure: out_ready low 3 cycles in DONE -> out_valid, sum, cout, ovf constant; in_ready=0; a concurrent in_valid is not accepted. out_ready high -> IDLE, in_ready=1 next cycle.
5. rst_n low for 1 cycle during RUN -> out_valid never asserts for that operation; in_ready=1 on the first cycle after rst_n returns high; the next operation is correct.
6. Parameter sweep (WIDTH,DIGIT) = (8,1), (8,8), (16,4), (12,3): 1000 random add/sub vectors vs a behavioural model; latency = NDIG every time.
